// File: rtl/nco_pkg.sv
// Shared NCO widths, FTW/offset types and the dither alignment helper.
package nco_pkg;

  localparam int unsigned NCO_ACC_W  = 24;
  localparam int unsigned NCO_ADDR_W = 10;
  localparam int unsigned NCO_DITH_W = 4;

  typedef logic [NCO_ACC_W-1:0]  ftw_t;
  typedef logic [NCO_ACC_W-1:0]  poff_t;
  typedef logic [NCO_ADDR_W-1:0] addr_t;

  // Bit position of the dither LSB: directly below the truncated address LSB.
  // Returns 0 for an illegal width combination so dependent widths stay legal
  // long enough for the elaboration check to report the real problem.
  function automatic int unsigned dith_shift(input int unsigned acc_w,
                                             input int unsigned addr_w,
                                             input int unsigned dith_w);
    if (acc_w >= addr_w + dith_w) return acc_w - addr_w - dith_w;
    return 0;
  endfunction

endpackage

// File: rtl/nco_ftw_shadow.sv
// Pending/active FTW double buffer with phase-continuous or immediate commit.
module nco_ftw_shadow
  import nco_pkg::*;
#(
  parameter int unsigned W              = NCO_ACC_W,
  parameter bit          COMMIT_ON_WRAP = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         carry_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] ftw_i,
  output logic [W-1:0] ftw_act_o,
  output logic         pend_o
);

  logic [W-1:0] act_q, act_d;
  logic [W-1:0] pftw_q, pftw_d;
  logic         pend_q, pend_d;
  logic         commit;

  // Commit decision and next-state; a load in the commit cycle re-arms pending.
  always_comb begin
    commit = COMMIT_ON_WRAP ? (clr_i | carry_i) : (en_i & pend_q);
    act_d  = commit ? pftw_q : act_q;
    pftw_d = load_i ? ftw_i : pftw_q;
    pend_d = pend_q;
    if (load_i)      pend_d = 1'b1;
    else if (commit) pend_d = 1'b0;
  end

  // Shadow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q  <= '0;
      pftw_q <= '0;
      pend_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      pftw_q <= pftw_d;
      pend_q <= pend_d;
    end
  end

  assign ftw_act_o = act_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator: FTW integration, offset + dither add, address truncation.
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W          = NCO_ACC_W,
  parameter int unsigned ADDR_W         = NCO_ADDR_W,
  parameter int unsigned DITH_W         = NCO_DITH_W,
  parameter bit          COMMIT_ON_WRAP = 1'b1
) (
  input  logic              iclk,
  input  logic              iresetn,
  input  logic              inCS,
  input  logic [ACC_W-1:0]  iftw,
  input  logic              iftw_load,
  input  logic [ACC_W-1:0]  ipoff,
  input  logic              ipoff_load,
  input  logic              iphase_clr,
  input  logic [DITH_W-1:0] idither,
  output logic [ADDR_W-1:0] oaddr,
  output logic              ovalid,
  output logic              owrap,
  output logic              opend
);

  localparam int unsigned SH = dith_shift(ACC_W, ADDR_W, DITH_W);

  if (ACC_W < ADDR_W + DITH_W) begin : g_width_check
    $fatal(1, "nco_phase_acc: ACC_W must be >= ADDR_W + DITH_W");
  end

  logic              en;
  logic [ACC_W:0]    acc_sum;
  logic              carry;
  logic [ACC_W-1:0]  ftw_act;
  logic [ACC_W-1:0]  dith_ext;
  logic [ACC_W-1:0]  phase_sum;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  poff_q, poff_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        fill_q, fill_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  assign en = ~inCS;

  nco_ftw_shadow #(
    .W              (ACC_W),
    .COMMIT_ON_WRAP (COMMIT_ON_WRAP)
  ) u_shadow (
    .clk_i     (iclk),
    .rst_ni    (iresetn),
    .en_i      (en),
    .carry_i   (carry & en & ~iphase_clr),
    .clr_i     (iphase_clr),
    .load_i    (iftw_load),
    .ftw_i     (iftw),
    .ftw_act_o (ftw_act),
    .pend_o    (opend)
  );

  // Datapath adders and next-state; clear overrides enable and leaves the address held.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {1'b0, ftw_act};
    carry     = acc_sum[ACC_W];
    dith_ext  = {{(ACC_W-DITH_W){1'b0}}, idither} << SH;
    phase_sum = acc_q + poff_q + dith_ext;

    acc_d   = acc_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    poff_d  = ipoff_load ? ipoff : poff_q;

    if (iphase_clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (en) begin
      acc_d   = acc_sum[ACC_W-1:0];
      addr_d  = phase_sum[ACC_W-1 -: ADDR_W];
      wrap_d  = carry;
      valid_d = (fill_q == 2'd2);
      if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
    end
  end

  // Pipeline registers.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      acc_q   <= '0;
      poff_q  <= '0;
      addr_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      poff_q  <= poff_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign oaddr  = addr_q;
  assign ovalid = valid_q;
  assign owrap  = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Self-checking bench for nco_phase_acc against a cycle-level arithmetic model.
module tb_nco_phase_acc;
  import nco_pkg::*;

  localparam int unsigned MOD  = 32'h0100_0000;
  localparam int unsigned MASK = 32'h00FF_FFFF;

  logic        iclk = 1'b0;
  logic        iresetn = 1'b0;
  logic        inCS = 1'b1;
  ftw_t        iftw = '0;
  logic        iftw_load = 1'b0;
  poff_t       ipoff = '0;
  logic        ipoff_load = 1'b0;
  logic        iphase_clr = 1'b0;
  logic [3:0]  idither = '0;
  addr_t       oaddr;
  logic        ovalid, owrap, opend;

  int unsigned total = 0;
  int unsigned passed = 0;

  // Reference state: plain integers, "since" counts enabled cycles after a clear.
  int unsigned m_acc, m_act, m_pend, m_poff, m_addr, m_since;
  bit          m_pending, m_valid, m_wrap;

  nco_phase_acc #(
    .ACC_W          (24),
    .ADDR_W         (10),
    .DITH_W         (4),
    .COMMIT_ON_WRAP (1'b1)
  ) dut (
    .iclk       (iclk),
    .iresetn    (iresetn),
    .inCS       (inCS),
    .iftw       (iftw),
    .iftw_load  (iftw_load),
    .ipoff      (ipoff),
    .ipoff_load (ipoff_load),
    .iphase_clr (iphase_clr),
    .idither    (idither),
    .oaddr      (oaddr),
    .ovalid     (ovalid),
    .owrap      (owrap),
    .opend      (opend)
  );

  always #5 iclk = ~iclk;

  task automatic model_reset();
    m_acc = 0; m_act = 0; m_pend = 0; m_poff = 0; m_addr = 0; m_since = 0;
    m_pending = 0; m_valid = 0; m_wrap = 0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic tick(input bit cs, input bit fl, input int unsigned f,
                      input bit pl, input int unsigned p, input bit clr,
                      input int unsigned d);
    bit          en, c, commit;
    int unsigned s, ph;
    inCS = cs; iftw_load = fl; iftw = f[23:0]; ipoff_load = pl; ipoff = p[23:0];
    iphase_clr = clr; idither = d[3:0];
    @(posedge iclk);
    en     = !cs;
    s      = m_acc + m_act;
    c      = en && !clr && (s >= MOD);
    ph     = (m_acc + m_poff + d * 1024) & MASK;
    commit = clr || c;
    if (clr) begin
      m_acc = 0; m_since = 0; m_valid = 0; m_wrap = 0;
    end else begin
      m_wrap  = c;
      m_valid = en && (m_since >= 2);
      if (en) begin
        m_addr  = ph >> 14;
        m_acc   = s & MASK;
        m_since = m_since + 1;
      end
    end
    if (commit) m_act = m_pend;
    if (fl) m_pend = f & MASK;
    if (fl) m_pending = 1;
    else if (commit) m_pending = 0;
    if (pl) m_poff = p & MASK;
    #1;
  endtask

  task automatic test_reset();
    iresetn = 1'b0;
    model_reset();
    #12;
    total++; if (oaddr !== 10'd0) $display("FAIL reset_oaddr got %0h want 0", oaddr); else passed++;
    total++; if (ovalid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", ovalid); else passed++;
    total++; if (owrap !== 1'b0)  $display("FAIL reset_owrap got %b want 0", owrap); else passed++;
    total++; if (opend !== 1'b0)  $display("FAIL reset_opend got %b want 0", opend); else passed++;
    @(negedge iclk);
    iresetn = 1'b1;
    @(posedge iclk); #1;
  endtask

  task automatic test_ftw_step();
    tick(1, 0, 0, 1, 0, 0, 0);
    tick(1, 1, 32'h004000, 0, 0, 0, 0);
    total++; if (opend !== 1'b1) $display("FAIL step_pend_set got %b want 1", opend); else passed++;
    tick(1, 0, 0, 0, 0, 1, 0);
    total++; if (opend !== 1'b0) $display("FAIL step_pend_commit got %b want 0", opend); else passed++;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (oaddr !== 10'(k - 1) || ovalid !== (k >= 3))
        $display("FAIL step_seq k=%0d got addr=%0d valid=%b want addr=%0d valid=%b",
                 k, oaddr, ovalid, k - 1, (k >= 3));
      else passed++;
    end
  endtask

  task automatic test_dither_offset();
    tick(1, 1, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 4'hF);
    tick(0, 0, 0, 0, 0, 0, 4'hF);
    total++; if (oaddr !== 10'd0) $display("FAIL dither_trunc got %0d want 0", oaddr); else passed++;
    tick(1, 0, 0, 1, 32'h000400, 0, 4'hF);
    tick(0, 0, 0, 0, 0, 0, 4'hF);
    total++; if (oaddr !== 10'd1) $display("FAIL dither_carry got %0d want 1", oaddr); else passed++;
    tick(1, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_wrap_commit();
    tick(1, 1, 32'h800000, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      tick(0, (k == 5), 32'h400000, 0, 0, 0, 0);
      total++;
      if (k <= 6) begin
        if (owrap !== (k % 2 == 0)) $display("FAIL wrap_half k=%0d got %b want %b", k, owrap, (k % 2 == 0));
        else passed++;
      end else begin
        if (owrap !== ((k - 6) % 4 == 0)) $display("FAIL wrap_quarter k=%0d got %b want %b", k, owrap, ((k - 6) % 4 == 0));
        else passed++;
      end
      if (k == 5) begin
        total++; if (opend !== 1'b1) $display("FAIL wrap_pend_hold got %b want 1", opend); else passed++;
      end
      if (k == 6) begin
        total++; if (opend !== 1'b0) $display("FAIL wrap_pend_commit got %b want 0", opend); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    addr_t frozen;
    tick(1, 1, $urandom_range(32'h00FFFF, 32'h1), 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 0, 0, $urandom_range(15, 0));
    frozen = oaddr;
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0, 0, 0, 0, $urandom_range(15, 0));
      total++;
      if (oaddr !== frozen || ovalid !== 1'b0 || owrap !== 1'b0)
        $display("FAIL stall_hold got addr=%0d valid=%b wrap=%b want addr=%0d valid=0 wrap=0",
                 oaddr, ovalid, owrap, frozen);
      else passed++;
    end
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 0, 0, 0, 0, $urandom_range(15, 0));
      total++;
      if (oaddr !== 10'(m_addr) || ovalid !== m_valid || owrap !== m_wrap)
        $display("FAIL stall_resume got addr=%0d valid=%b wrap=%b want addr=%0d valid=%b wrap=%b",
                 oaddr, ovalid, owrap, m_addr, m_valid, m_wrap);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    tick(1, 1, 32'h800000, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    tick(1, 1, 32'h100000, 0, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (m_acc + m_act >= MOD) begin
        tick(0, 1, 32'h300000, 0, 0, 0, 0);
        found = 1;
      end else tick(0, 0, 0, 0, 0, 0, 0);
    end
    total++; if (!found) $display("FAIL simul_find_wrap got none want wrap"); else passed++;
    total++; if (opend !== 1'b1) $display("FAIL simul_pend got %b want 1", opend); else passed++;
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (oaddr !== 10'(m_addr) || owrap !== m_wrap || opend !== m_pending)
        $display("FAIL simul_track got addr=%0d wrap=%b pend=%b want addr=%0d wrap=%b pend=%b",
                 oaddr, owrap, opend, m_addr, m_wrap, m_pending);
      else passed++;
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    total++;
    if (oaddr !== 10'(m_addr) || ovalid !== 1'b0 || owrap !== 1'b0)
      $display("FAIL clr_en got addr=%0d valid=%b wrap=%b want addr=%0d valid=0 wrap=0",
               oaddr, ovalid, owrap, m_addr);
    else passed++;
    for (int k = 1; k <= 3; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (ovalid !== (k == 3)) $display("FAIL clr_valid k=%0d got %b want %b", k, ovalid, (k == 3));
      else passed++;
      if (k == 1) begin
        total++; if (oaddr !== 10'd0) $display("FAIL clr_acc_zero got %0d want 0", oaddr); else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      tick(($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), $urandom,
           ($urandom_range(7, 0) == 0), $urandom, ($urandom_range(31, 0) == 0),
           $urandom_range(15, 0));
      total++;
      if (oaddr !== 10'(m_addr) || ovalid !== m_valid || owrap !== m_wrap || opend !== m_pending)
        $display("FAIL random k=%0d got addr=%0d v=%b w=%b p=%b want addr=%0d v=%b w=%b p=%b",
                 k, oaddr, ovalid, owrap, opend, m_addr, m_valid, m_wrap, m_pending);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    tick(1, 1, 32'h123456, 1, 32'h0ABCDE, 1, 0);
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0, 0, 0, $urandom_range(15, 0));
    #2 iresetn = 1'b0;
    model_reset();
    #1;
    total++;
    if (oaddr !== 10'd0 || ovalid !== 1'b0 || owrap !== 1'b0 || opend !== 1'b0)
      $display("FAIL async_reset got addr=%0d v=%b w=%b p=%b want all 0", oaddr, ovalid, owrap, opend);
    else passed++;
    @(negedge iclk);
    iresetn = 1'b1;
    @(posedge iclk); #1;
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (oaddr !== 10'd0 || owrap !== 1'b0)
        $display("FAIL post_reset_idle got addr=%0d wrap=%b want addr=0 wrap=0", oaddr, owrap);
      else passed++;
    end
    tick(1, 1, 32'h004000, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 0, 0, 0);
    total++; if (oaddr !== 10'd3) $display("FAIL post_reset_resume got %0d want 3", oaddr); else passed++;
  endtask

  initial begin
    test_reset();
    test_ftw_step();
    test_dither_offset();
    test_wrap_commit();
    test_stall();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nco_phase_acc.md
Name: nco_phase_acc

Overview:
- Phase accumulator stage of the NCO, directly downstream of the 4-bit LFSR dither generator.
- Integrates a frequency tuning word (FTW) and adds a phase offset plus the dither word just below the truncation point.
- Outputs a truncated phase address to the sine LUT stage.
- Advances on the same active-low chip-select as the dither source, so both stay cycle-aligned.

Parameters:
- ACC_W, 24, accumulator/FTW/offset width.
- ADDR_W, 10, output LUT address width.
- DITH_W, 4, dither input width.
- COMMIT_ON_WRAP, 1: 1 = pending FTW applied at next accumulator wrap (phase-continuous); 0 = applied on next enabled cycle.

Ports:
- iclk  in  1  clock.
- iresetn  in  1  asynchronous active-low reset.
- inCS  in  1  active-low enable; pipeline advances only when low.
- iftw  in  ACC_W  tuning word data.
- iftw_load  in  1  one-cycle strobe, captures iftw into the pending register.
- ipoff  in  ACC_W  phase offset data.
- ipoff_load  in  1  strobe, captures ipoff (applied immediately).
- iphase_clr  in  1  synchronous accumulator clear.
- idither  in  DITH_W  registered dither word from the dither generator.
- oaddr  out  ADDR_W  truncated dithered phase.
- ovalid  out  1  oaddr holds fresh data.
- owrap  out  1  one-cycle pulse on accumulator carry-out.
- opend  out  1  an FTW is pending and not yet committed.

Behaviour:
- Reset is asynchronous on iresetn low. acc, ftw_act, ftw_pend, poff, oaddr, fill are all 0. ovalid=0, owrap=0, opend=0.
- Elaboration check: ACC_W >= ADDR_W+DITH_W, else fatal.
- Define SH = ACC_W-ADDR_W-DITH_W. Dither is zero-extended and shifted left by SH, so it sits directly below the address LSB.
- Loads (independent of inCS):
  - iftw_load: ftw_pend <= iftw, opend <= 1.
  - ipoff_load: poff <= ipoff.
- Stage 1, when ~inCS: {carry, acc} <= acc + ftw_act, computed mod 2^ACC_W. owrap <= carry.
- owrap is forced to 0 on any cycle where inCS is high.
- Stage 2, when ~inCS: sum = (acc + poff + (idither << SH)) mod 2^ACC_W, then oaddr <= sum[ACC_W-1 -: ADDR_W].
- Latency: an acc value reaches oaddr one enabled cycle after it is registered. FTW-to-address latency is 2 enabled cycles. owrap leads the corresponding oaddr by one enabled cycle.
- ovalid uses a 2-bit saturating fill counter that increments per enabled cycle.
  - ovalid <= ~inCS & (fill == 2).
  - When inCS is high, ovalid=0 and all pipeline registers hold.
- Commit:
  - COMMIT_ON_WRAP=1: commit on an enabled cycle with carry=1, or on iphase_clr.
  - COMMIT_ON_WRAP=0: commit on any enabled cycle with opend=1.
  - On commit: ftw_act <= ftw_pend, opend <= 0. The new ftw_act is used from the following addition.
- Simultaneous events:
  - iftw_load with commit in the same cycle: the old pending value commits, the new value becomes pending, and opend stays 1.
  - iphase_clr has highest priority and acts regardless of inCS: acc <= 0, fill <= 0, ovalid <= 0, owrap <= 0. oaddr holds its value. A clear together with enable performs no accumulation that cycle.
- Reset mid-operation: everything returns to reset values immediately, and ftw_act=0 until the next load and commit.

Decomposition:
- Package nco_pkg holds:
  - default widths ACC_W, ADDR_W, DITH_W;
  - helper constant function dith_shift(ACC_W, ADDR_W, DITH_W);
  - FTW/offset typedefs shared with the LUT stage.
- One natural sub-module, nco_ftw_shadow. It contains the pending/active FTW registers, opend, and the commit logic, and takes carry, enable and clear as inputs.
- The accumulator and dither adder stay in the top.

Test Plan (ACC_W=24, ADDR_W=10, DITH_W=4, SH=10):
- FTW step: reset, load FTW=0x004000, idither=0, poff=0, inCS low → ovalid rises after 2 enabled cycles, then oaddr = 1,2,3,… one per cycle.
- Dither/offset truncation: FTW=0, idither=4'hF, poff=0 → sum 0x003C00, oaddr=0. Load poff=0x000400 → sum 0x004000, oaddr=1.
- Wrap and phase-continuous commit (COMMIT_ON_WRAP=1): FTW=0x800000 → owrap pulses every 2nd enabled cycle. Loading FTW=0x400000 mid-period keeps opend=1 until the next owrap, after which owrap occurs every 4th cycle.
- Stall: hold inCS high for 5 cycles mid-sequence → oaddr frozen, ovalid=0, owrap=0. On release, the sequence resumes with no skipped or repeated address.
- Simultaneous events: iftw_load coincident with a wrap commit → old pending value becomes active and opend remains 1. iphase_clr together with ~inCS → acc=0, ovalid low for 2 enabled cycles.
- Async reset mid-run: pulse iresetn low between clock edges → all outputs 0 immediately. After release, no accumulation until an FTW load and commit.
